// File: rtl/shift_serializer.sv
// MSB-first parallel-to-serial transmitter with valid/ready input and done pulse.
// Define SHIFT_SERIALIZER_CHECK_EN to add the receiver readback compare (chk_word/chk_err).
module shift_serializer #(
    parameter int   WIDTH      = 8,
    parameter logic IDLE_LEVEL = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             sout,
    output logic             sout_en,
    output logic             busy,
    output logic             done
`ifdef SHIFT_SERIALIZER_CHECK_EN
    ,
    input  logic [WIDTH-1:0] chk_word,
    output logic             chk_err
`endif
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic             sout_q, sout_d;
    logic             sout_en_q, sout_en_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             last_bit;
    logic             take;

    assign last_bit  = (state_q == SHIFT) && (count_q == LAST);
    assign din_ready = (state_q == IDLE) || last_bit;
    assign take      = din_valid && din_ready;

    assign sout    = sout_q;
    assign sout_en = sout_en_q;
    assign busy    = busy_q;
    assign done    = done_q;

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        shreg_d   = shreg_q;
        sout_d    = sout_q;
        sout_en_d = sout_en_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (take) begin
                    state_d   = SHIFT;
                    shreg_d   = din;
                    sout_d    = din[WIDTH-1];
                    sout_en_d = 1'b1;
                    busy_d    = 1'b1;
                    count_d   = '0;
                end
            end
            SHIFT: begin
                if (count_q != LAST) begin
                    shreg_d = shreg_q << 1;
                    sout_d  = shreg_q[WIDTH-2];
                    count_d = count_q + 1'b1;
                end else begin
                    done_d = 1'b1;
                    // Reload on the last-bit edge keeps frames gapless
                    if (take) begin
                        shreg_d = din;
                        sout_d  = din[WIDTH-1];
                        count_d = '0;
                    end else begin
                        state_d   = IDLE;
                        sout_d    = IDLE_LEVEL;
                        sout_en_d = 1'b0;
                        busy_d    = 1'b0;
                        count_d   = '0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            count_q   <= '0;
            shreg_q   <= '0;
            sout_q    <= IDLE_LEVEL;
            sout_en_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            shreg_q   <= shreg_d;
            sout_q    <= sout_d;
            sout_en_q <= sout_en_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

`ifdef SHIFT_SERIALIZER_CHECK_EN
    logic [WIDTH-1:0] shadow_q, shadow_d;
    logic             pend_q, pend_d;
    logic             chk_err_q, chk_err_d;

    assign chk_err = chk_err_q;

    // Shadow captures the word one edge after acceptance, from the still-unshifted shreg
    always_comb begin
        pend_d    = take;
        shadow_d  = pend_q ? shreg_q : shadow_q;
        chk_err_d = chk_err_q;
        if (done_q) begin
            chk_err_d = (chk_word != shadow_q);
        end else if (take) begin
            chk_err_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shadow_q  <= '0;
            pend_q    <= 1'b0;
            chk_err_q <= 1'b0;
        end else begin
            shadow_q  <= shadow_d;
            pend_q    <= pend_d;
            chk_err_q <= chk_err_d;
        end
    end
`endif

endmodule

// File: tb/tb_shift_serializer.sv
// Scoreboard bench for shift_serializer: driver queues accepted words,
// monitor rebuilds each frame from sout and checks framing and handshake.
module tb_shift_serializer;

    localparam int   W    = 8;
    localparam logic IDLE = 1'b0;

    logic         clk = 1'b0;
    logic         reset;
    logic [W-1:0] din;
    logic         din_valid;
    logic         din_ready;
    logic         sout;
    logic         sout_en;
    logic         busy;
    logic         done;
`ifdef SHIFT_SERIALIZER_CHECK_EN
    logic [W-1:0] rx_reg;
    logic         chk_err;
`endif

    int total = 0;
    int bad   = 0;

    logic [W-1:0] exp_q[$];
    logic [W-1:0] got_w;
    int           nbits;

    always #5 clk = ~clk;

    shift_serializer #(
        .WIDTH(W),
        .IDLE_LEVEL(IDLE)
    ) dut (
        .clk(clk),
        .reset(reset),
        .din(din),
        .din_valid(din_valid),
        .din_ready(din_ready),
        .sout(sout),
        .sout_en(sout_en),
        .busy(busy),
        .done(done)
`ifdef SHIFT_SERIALIZER_CHECK_EN
        ,
        .chk_word(rx_reg),
        .chk_err(chk_err)
`endif
    );

`ifdef SHIFT_SERIALIZER_CHECK_EN
    // Receiver: shift left, insert at bit 0
    always @(posedge clk or posedge reset) begin
        if (reset) rx_reg <= '0;
        else if (sout_en) rx_reg <= {rx_reg[W-2:0], sout};
    end
`endif

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: reference receiver assembles the bit stream into words
    always @(negedge clk) begin
        if (reset) begin
            check("rst_sout", int'(sout), int'(IDLE));
            check("rst_sout_en", int'(sout_en), 0);
            check("rst_busy", int'(busy), 0);
            check("rst_done", int'(done), 0);
            check("rst_ready", int'(din_ready), 1);
            exp_q.delete();
            nbits = 0;
            got_w = '0;
        end else begin
            check("done_timing", int'(done), int'(nbits == W));
            if (done) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL word: got=%0h expected=none", got_w);
                end else begin
                    check("word", int'(got_w), int'(exp_q.pop_front()));
                end
                nbits = 0;
            end
            if (sout_en) begin
                got_w = {got_w[W-2:0], sout};
                nbits++;
            end else begin
                check("idle_sout", int'(sout), int'(IDLE));
            end
            check("busy", int'(busy), int'(sout_en));
            check("ready", int'(din_ready), int'(!sout_en || nbits == W));
`ifdef SHIFT_SERIALIZER_CHECK_EN
            check("chk_err", int'(chk_err), 0);
`endif
        end
    end

    // Present a word and hold it until the handshake completes
    task automatic send(input logic [W-1:0] w);
        int guard = 0;
        @(negedge clk);
        #1;
        din       = w;
        din_valid = 1'b1;
        while (!din_ready && guard < 40) begin
            @(negedge clk);
            #1;
            guard++;
        end
        if (!din_ready) begin
            total++;
            bad++;
            $display("FAIL accept_timeout: got=ready0 expected=ready1");
        end else begin
            exp_q.push_back(w);
        end
        @(posedge clk);
        #1;
        din_valid = 1'b0;
        din       = $urandom;
    endtask

    task automatic drain();
        int guard = 0;
        while ((exp_q.size() != 0 || sout_en) && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        check("drain", exp_q.size(), 0);
    endtask

    initial begin
        reset     = 1'b1;
        din       = '0;
        din_valid = 1'b0;
        nbits     = 0;
        got_w     = '0;
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;

        send(8'hA5);
        drain();

        send(8'h3C);
        send(8'hC3);
        drain();

        send(8'h55);
        repeat (3) @(posedge clk);
        send(8'hFF);
        drain();

        send(8'h81);
        repeat (4) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        check("abort_sout_en", int'(sout_en), 0);
        check("abort_busy", int'(busy), 0);
        check("abort_sout", int'(sout), int'(IDLE));
        check("abort_ready", int'(din_ready), 1);
        @(negedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        send(8'h01);
        drain();

        for (int i = 0; i < 150; i++) begin
            if ($urandom_range(0, 1) == 0) begin
                repeat ($urandom_range(1, 10)) @(posedge clk);
            end
            send(W'($urandom));
        end
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
